spi_ram_host_arbiter: RTL and testbench
=======================================

Name: spi_ram_host_arbiter

Overview:
- Host-side controller that shares the SPI-slave/RAM subsystem between two requesters.
- Round-robin arbitrates byte read/write requests.
- Serialises each request into the slave's 11-bit command frames on SS_n/MOSI and deserialises read data from MISO.
- Returns a tagged one-cycle response; drives the subsystem's MOSI, SS_n, MISO pins directly.

Parameters:
- ADDR_SIZE, 8, RAM address width (payload width of address frames)
- DATA_SIZE, 8, RAM data width (payload width of data/read frames)
- READ_LAT, 2, clk cycles from last MOSI bit of a read-data frame to first valid MISO bit
- GAP_CYC, 1, minimum SS_n-high cycles between consecutive frames (>=1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has a request
- req0_ready  out  1  requester 0 request accepted this cycle
- req0_rw  in  1  0=write, 1=read
- req0_addr  in  ADDR_SIZE  target address
- req0_wdata  in  DATA_SIZE  write data (ignored for reads)
- req1_valid, req1_ready, req1_rw, req1_addr, req1_wdata: same as requester 0
- rsp_valid  out  1  one-cycle response pulse
- rsp_id  out  1  requester that owns the response
- rsp_rdata  out  DATA_SIZE  read data; 0 for writes
- SS_n  out  1  slave select, active low
- MOSI  out  1  serial data to slave, MSB first
- MISO  in  1  serial data from slave

Behaviour:
- Reset (async assert, sync release) values:
  - SS_n=1, MOSI=0, req*_ready=0, rsp_valid=0, rsp_id=0, rsp_rdata=0.
  - State IDLE, last_grant=1, so requester 0 wins the first tie.
- Frame format: SS_n low for 11 cycles. MOSI carries {cmd[1], cmd[1:0], payload} MSB first, one bit per clk.
- Command codes: 00 = write-address, 01 = write-data, 10 = read-address, 11 = read-data (payload = 0).
- Request expansion:
  - Write: frames 00+addr, then 01+wdata.
  - Read: frames 10+addr, then 11+0.
- States: IDLE, SEND, RD_WAIT, RECV, GAP, RESP.
- IDLE:
  - If any valid, grant one; assert only that req*_ready for exactly one cycle; capture rw/addr/wdata/id; go to SEND next cycle.
  - Both valid: grant the requester not equal to last_grant, then update last_grant.
  - Never both ready in the same cycle.
- SEND:
  - SS_n=0, 11-bit shift counter.
  - After the 11th bit: if the frame was read-data, go to RD_WAIT with SS_n held low; otherwise go to GAP with SS_n=1.
- RD_WAIT: SS_n=0, MOSI=0 for READ_LAT cycles, then RECV.
- RECV: SS_n=0; sample MISO on DATA_SIZE consecutive edges MSB first into the shift register; then GAP with SS_n=1.
- GAP:
  - SS_n=1 for GAP_CYC cycles.
  - If the second frame of the request is still pending, go to SEND; otherwise go to RESP.
- RESP:
  - rsp_valid=1 for one cycle with rsp_id and rsp_rdata (0 for writes); then IDLE.
  - rsp_rdata holds its value until the next response.
- Back-to-back requests: earliest ready for the next request is the cycle after RESP.
- Write latency, accept cycle to rsp_valid: 1 + 2*(11 + GAP_CYC) + 1 = 26 cycles at defaults.
- Read latency at defaults: 1 + 11 + GAP_CYC + 11 + READ_LAT + DATA_SIZE + GAP_CYC + 1 = 36 cycles.
- valid dropping before ready: no effect, request not taken. Inputs are sampled only on the ready cycle.
- Reset mid-frame:
  - Immediate abort, SS_n=1, no response issued; in-flight request is lost.
  - The slave is reset by the same rst_n.

Optional Feature:
- Macro: SPI_ADDR_CACHE_EN.
- Defined:
  - Keep last write address and last read address, each with a valid flag; both cleared on reset.
  - Skip the address frame (go straight to the data frame) when the request's address equals the cached address of the same type and the flag is set.
  - Update the cache after every address frame sent.
  - Saves 11 + GAP_CYC cycles per hit.
- Undefined: every request always sends both frames; no cache registers exist.

Test Plan:
- Single write, req0 addr=0x3C wdata=0xA5 -> MOSI frames 0_00_00111100 then 0_01_10100101; rsp_valid at cycle 26, rsp_id=0, rsp_rdata=0.
- Read after write, req1 read addr=0x3C with MISO model returning 0xA5 -> frames 1_10_00111100 and 1_11_00000000; rsp_valid at cycle 36, rsp_id=1, rsp_rdata=0xA5.
- Both valid continuously from reset -> grants alternate 0,1,0,1; never both ready; four responses with ids 0,1,0,1.
- rst_n pulled low at bit 5 of a write-data frame -> SS_n=1 and MOSI=0 the same cycle; no rsp_valid; after release, first grant goes to req0.
- SS_n gap check, two back-to-back writes -> SS_n high for exactly GAP_CYC cycles between every pair of frames and never low for more than 11 cycles on non-read frames.
- SPI_ADDR_CACHE_EN defined, two writes to addr 0x10 -> second write sends only the 01 frame; rsp latency 14 cycles.

Source files
------------

// File: rtl/spi_ram_host_arbiter_if.sv
// Requester, response and SPI pin bundle for spi_ram_host_arbiter.
// master = requesters/subsystem side, slave = the arbiter itself.
interface spi_ram_host_arbiter_if #(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 8
);
  logic                 req0_valid, req0_ready, req0_rw;
  logic [ADDR_SIZE-1:0] req0_addr;
  logic [DATA_SIZE-1:0] req0_wdata;
  logic                 req1_valid, req1_ready, req1_rw;
  logic [ADDR_SIZE-1:0] req1_addr;
  logic [DATA_SIZE-1:0] req1_wdata;
  logic                 rsp_valid, rsp_id;
  logic [DATA_SIZE-1:0] rsp_rdata;
  logic                 SS_n, MOSI, MISO;

  modport master (
    output req0_valid, req0_rw, req0_addr, req0_wdata,
    output req1_valid, req1_rw, req1_addr, req1_wdata, MISO,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_rdata, SS_n, MOSI
  );

  modport slave (
    input  req0_valid, req0_rw, req0_addr, req0_wdata,
    input  req1_valid, req1_rw, req1_addr, req1_wdata, MISO,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_rdata, SS_n, MOSI
  );
endinterface

// File: rtl/spi_ram_host_arbiter.sv
// Two-requester round-robin host for the SPI-slave/RAM: each request becomes an
// address frame plus a data frame. Optional SPI_ADDR_CACHE_EN skips repeated address frames.
module spi_ram_host_arbiter #(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 8,
  parameter int READ_LAT  = 2,
  parameter int GAP_CYC   = 1
) (
  input  logic clk,
  input  logic rst_n,
  spi_ram_host_arbiter_if.slave bus
);
  localparam int PW = (ADDR_SIZE > DATA_SIZE) ? ADDR_SIZE : DATA_SIZE;
  localparam int FW = PW + 3;
  localparam int CW = 16;
  localparam logic [CW-1:0] LEN_A = CW'(3 + ADDR_SIZE);
  localparam logic [CW-1:0] LEN_D = CW'(3 + DATA_SIZE);
  localparam logic [CW-1:0] C_RL  = CW'(READ_LAT);
  localparam logic [CW-1:0] C_DS  = CW'(DATA_SIZE);
  localparam logic [CW-1:0] C_GAP = CW'(GAP_CYC);

  typedef enum logic [2:0] {IDLE, SEND, RD_WAIT, RECV, GAP, RESP} state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt, r_len;
  logic [FW-1:0]        r_frame;
  logic                 r_second, r_rw, r_id, r_last_grant;
  logic [DATA_SIZE-1:0] r_wdata, r_rx;
  logic                 r_ss_n, r_mosi, r_rsp_valid, r_rsp_id;
  logic [DATA_SIZE-1:0] r_rsp_rdata;

  logic                 w_g0, w_g1, w_acc, w_rw, w_hit;
  logic [ADDR_SIZE-1:0] w_addr;
  logic [DATA_SIZE-1:0] w_wdata;
  logic [FW-1:0]        w_first, w_second;

  // Frames are left-justified so the MSB of every frame type leaves first.
  function automatic logic [FW-1:0] mk_addr(input logic rw, input logic [ADDR_SIZE-1:0] a);
    return FW'({rw, rw, 1'b0, a}) << (PW - ADDR_SIZE);
  endfunction

  function automatic logic [FW-1:0] mk_data(input logic rw, input logic [DATA_SIZE-1:0] d);
    return FW'({rw, rw, 1'b1, (rw ? {DATA_SIZE{1'b0}} : d)}) << (PW - DATA_SIZE);
  endfunction

  // Ready is combinational so a valid that drops before grant is simply never taken.
  assign w_g0  = rst_n && (r_state == IDLE) && bus.req0_valid && (!bus.req1_valid || r_last_grant);
  assign w_g1  = rst_n && (r_state == IDLE) && bus.req1_valid && (!bus.req0_valid || !r_last_grant);
  assign w_acc = w_g0 || w_g1;
  assign bus.req0_ready = w_g0;
  assign bus.req1_ready = w_g1;

  assign w_rw    = w_g1 ? bus.req1_rw    : bus.req0_rw;
  assign w_addr  = w_g1 ? bus.req1_addr  : bus.req0_addr;
  assign w_wdata = w_g1 ? bus.req1_wdata : bus.req0_wdata;

  assign w_first  = w_hit ? mk_data(w_rw, w_wdata) : mk_addr(w_rw, w_addr);
  assign w_second = mk_data(r_rw, r_wdata);

`ifdef SPI_ADDR_CACHE_EN
  logic                 r_wc_v, r_rc_v;
  logic [ADDR_SIZE-1:0] r_wc_a, r_rc_a, r_addr;

  assign w_hit = w_rw ? (r_rc_v && (r_rc_a == w_addr)) : (r_wc_v && (r_wc_a == w_addr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wc_v <= 1'b0;
      r_rc_v <= 1'b0;
      r_wc_a <= '0;
      r_rc_a <= '0;
      r_addr <= '0;
    end else begin
      if (w_acc) r_addr <= w_addr;
      if (r_state == SEND && r_cnt == r_len && !r_second) begin
        if (r_rw) begin
          r_rc_v <= 1'b1;
          r_rc_a <= r_addr;
        end else begin
          r_wc_v <= 1'b1;
          r_wc_a <= r_addr;
        end
      end
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_len        <= '0;
      r_frame      <= '0;
      r_second     <= 1'b0;
      r_rw         <= 1'b0;
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;
      r_wdata      <= '0;
      r_rx         <= '0;
      r_ss_n       <= 1'b1;
      r_mosi       <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_rdata  <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_acc) begin
          r_id         <= w_g1;
          r_last_grant <= w_g1;
          r_rw         <= w_rw;
          r_wdata      <= w_wdata;
          r_second     <= w_hit;
          r_frame      <= w_first << 1;
          r_mosi       <= w_first[FW-1];
          r_len        <= w_hit ? LEN_D : LEN_A;
          r_cnt        <= CW'(1);
          r_ss_n       <= 1'b0;
          r_state      <= SEND;
        end
        SEND: begin
          if (r_cnt < r_len) begin
            r_mosi  <= r_frame[FW-1];
            r_frame <= r_frame << 1;
            r_cnt   <= r_cnt + CW'(1);
          end else if (r_second && r_rw) begin
            // Read-data frame: SS_n stays low while the slave turns data around.
            r_mosi  <= 1'b0;
            r_cnt   <= CW'(1);
            r_state <= (READ_LAT == 0) ? RECV : RD_WAIT;
          end else begin
            r_mosi  <= 1'b0;
            r_ss_n  <= 1'b1;
            r_cnt   <= CW'(1);
            r_state <= GAP;
          end
        end
        RD_WAIT: begin
          if (r_cnt < C_RL) r_cnt <= r_cnt + CW'(1);
          else begin
            r_cnt   <= CW'(1);
            r_state <= RECV;
          end
        end
        RECV: begin
          r_rx <= {r_rx[DATA_SIZE-2:0], bus.MISO};
          if (r_cnt < C_DS) r_cnt <= r_cnt + CW'(1);
          else begin
            r_ss_n  <= 1'b1;
            r_cnt   <= CW'(1);
            r_state <= GAP;
          end
        end
        GAP: begin
          if (r_cnt < C_GAP) r_cnt <= r_cnt + CW'(1);
          else if (!r_second) begin
            r_second <= 1'b1;
            r_frame  <= w_second << 1;
            r_mosi   <= w_second[FW-1];
            r_len    <= LEN_D;
            r_cnt    <= CW'(1);
            r_ss_n   <= 1'b0;
            r_state  <= SEND;
          end else begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_rdata <= r_rw ? r_rx : {DATA_SIZE{1'b0}};
            r_state     <= RESP;
          end
        end
        RESP: begin
          r_rsp_valid <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.SS_n      = r_ss_n;
  assign bus.MOSI      = r_mosi;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_rdata = r_rsp_rdata;
endmodule

// File: tb/tb_spi_ram_host_arbiter.sv
// Directed bench for spi_ram_host_arbiter: a cycle-level waveform model derived from
// the frame rules is compared against the pins every cycle; literal checks pin the model.
module tb_spi_ram_host_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_ram_host_arbiter_if #(.ADDR_SIZE(8), .DATA_SIZE(8)) bus ();

  spi_ram_host_arbiter #(.ADDR_SIZE(8), .DATA_SIZE(8), .READ_LAT(2), .GAP_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  localparam int RL = 2;
  localparam int GC = 1;

  typedef struct {
    bit ss, mosi, miso, rsp, id, rw;
    logic [7:0] addr, wd, data;
  } ent_t;

  ent_t q[$];
  int   nchk = 0, nfail = 0, cyc = 0, rsp_cnt = 0;
  bit   lg = 1'b1;
  logic [7:0] mem [256];
  logic [7:0] last_rdata = 8'h00;
  int   acc_cyc[$], rsp_cyc[$], gid[$], rid[$];
  logic [7:0]  rdat[$];
  logic [10:0] frames[$];
  logic [10:0] sh = '0;
  int   lowcnt = 0;
`ifdef SPI_ADDR_CACHE_EN
  bit wcv = 0, rcv = 0;
  logic [7:0] wca = 0, rca = 0;
`endif

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    nchk++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  function automatic ent_t mk(input bit ss, input bit mosi, input bit miso);
    ent_t e;
    e.ss = ss; e.mosi = mosi; e.miso = miso; e.rsp = 0; e.id = 0; e.rw = 0;
    e.addr = 0; e.wd = 0; e.data = 0;
    return e;
  endfunction

  task automatic push_frame(input logic [10:0] f);
    for (int i = 10; i >= 0; i--) q.push_back(mk(1'b0, f[i], 1'b0));
  endtask

  // Expected pin activity, one entry per cycle after the accept cycle.
  task automatic build(input bit id, input bit rw, input logic [7:0] a, input logic [7:0] wd);
    bit skip = 0;
    logic [7:0] rd = 8'h00;
    ent_t e;
`ifdef SPI_ADDR_CACHE_EN
    skip = rw ? (rcv && rca == a) : (wcv && wca == a);
    if (rw) begin rcv = 1; rca = a; end else begin wcv = 1; wca = a; end
`endif
    if (!skip) begin
      push_frame({rw, rw, 1'b0, a});
      for (int i = 0; i < GC; i++) q.push_back(mk(1'b1, 1'b0, 1'b0));
    end
    if (!rw) push_frame({3'b001, wd});
    else begin
      push_frame({3'b111, 8'h00});
      for (int i = 0; i < RL; i++) q.push_back(mk(1'b0, 1'b0, 1'b0));
      rd = mem[a];
      for (int i = 7; i >= 0; i--) q.push_back(mk(1'b0, 1'b0, rd[i]));
    end
    for (int i = 0; i < GC; i++) q.push_back(mk(1'b1, 1'b0, 1'b0));
    e = mk(1'b1, 1'b0, 1'b0);
    e.rsp = 1; e.id = id; e.rw = rw; e.addr = a; e.wd = wd; e.data = rw ? rd : 8'h00;
    q.push_back(e);
  endtask

  always @(posedge clk) cyc++;

  // Compare process: every cycle, pins vs model.
  always @(negedge clk) begin
    ent_t e;
    bit have, eg0, eg1;
    if (!rst_n) begin
      q.delete();
      lg = 1'b1;
      last_rdata = 8'h00;
      bus.MISO = 1'b0;
`ifdef SPI_ADDR_CACHE_EN
      wcv = 0; rcv = 0;
`endif
      chk("rst_ss_n", bus.SS_n, 1);
      chk("rst_mosi", bus.MOSI, 0);
      chk("rst_ready0", bus.req0_ready, 0);
      chk("rst_ready1", bus.req1_ready, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_id", bus.rsp_id, 0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    end else begin
      have = (q.size() > 0);
      e = have ? q.pop_front() : mk(1'b1, 1'b0, 1'b0);
      bus.MISO = e.miso;
      chk("ss_n", bus.SS_n, e.ss);
      chk("mosi", bus.MOSI, e.mosi);
      chk("rsp_valid", bus.rsp_valid, e.rsp);
      if (e.rsp) begin
        chk("rsp_id", bus.rsp_id, e.id);
        chk("rsp_rdata", bus.rsp_rdata, e.data);
        last_rdata = e.data;
        if (!e.rw) mem[e.addr] = e.wd;
        rsp_cyc.push_back(cyc); rid.push_back(bus.rsp_id); rdat.push_back(bus.rsp_rdata);
        rsp_cnt++;
      end else chk("rsp_rdata_hold", bus.rsp_rdata, last_rdata);
      eg0 = !have && bus.req0_valid && (!bus.req1_valid || lg);
      eg1 = !have && bus.req1_valid && (!bus.req0_valid || !lg);
      chk("ready0", bus.req0_ready, eg0);
      chk("ready1", bus.req1_ready, eg1);
      if (eg0 || eg1) begin
        lg = eg1;
        gid.push_back(eg1); acc_cyc.push_back(cyc);
        if (eg1) build(1'b1, bus.req1_rw, bus.req1_addr, bus.req1_wdata);
        else     build(1'b0, bus.req0_rw, bus.req0_addr, bus.req0_wdata);
      end
    end
  end

  // Frame capture: first 11 bits of each SS_n-low window.
  always @(negedge clk) begin
    if (!rst_n || bus.SS_n) lowcnt = 0;
    else begin
      if (lowcnt < 11) begin
        sh = {sh[9:0], bus.MOSI};
        lowcnt++;
        if (lowcnt == 11) frames.push_back(sh);
      end
    end
  end

  task automatic clr();
    acc_cyc.delete(); rsp_cyc.delete(); gid.delete(); rid.delete(); rdat.delete(); frames.delete();
  endtask

  task automatic do_req(input bit id, input bit rw, input logic [7:0] a, input logic [7:0] wd);
    int n = 0;
    if (id) begin bus.req1_rw = rw; bus.req1_addr = a; bus.req1_wdata = wd; bus.req1_valid = 1; end
    else    begin bus.req0_rw = rw; bus.req0_addr = a; bus.req0_wdata = wd; bus.req0_valid = 1; end
    while (n < 300) begin
      @(negedge clk);
      if (id ? bus.req1_ready : bus.req0_ready) break;
      n++;
    end
    if (n >= 300) chk("ready_timeout", 0, 1);
    @(posedge clk); #1;
    if (id) bus.req1_valid = 0; else bus.req0_valid = 0;
  endtask

  task automatic wait_rsp(input int target);
    int n = 0;
    while (rsp_cnt < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (rsp_cnt < target) chk("rsp_timeout", rsp_cnt, target);
    @(posedge clk); #1;
  endtask

  initial begin
    int base;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    bus.req0_valid = 0; bus.req0_rw = 0; bus.req0_addr = 0; bus.req0_wdata = 0;
    bus.req1_valid = 0; bus.req1_rw = 0; bus.req1_addr = 0; bus.req1_wdata = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // Both valid from reset: alternating grants, read sees the prior write.
    bus.req0_rw = 0; bus.req0_addr = 8'h01; bus.req0_wdata = 8'h11; bus.req0_valid = 1;
    bus.req1_rw = 1; bus.req1_addr = 8'h01; bus.req1_wdata = 8'h00; bus.req1_valid = 1;
    for (int n = 0; n < 400 && gid.size() < 4; n++) begin @(posedge clk); #1; end
    bus.req0_valid = 0; bus.req1_valid = 0;
    wait_rsp(4);
    chk("rr_count", gid.size(), 4);
    if (gid.size() == 4) begin
      chk("rr_g0", gid[0], 0); chk("rr_g1", gid[1], 1);
      chk("rr_g2", gid[2], 0); chk("rr_g3", gid[3], 1);
    end
    if (rid.size() == 4) begin
      chk("rr_rid0", rid[0], 0); chk("rr_rid1", rid[1], 1);
      chk("rr_rid2", rid[2], 0); chk("rr_rid3", rid[3], 1);
      chk("rr_rdata1", rdat[1], 8'h11);
    end

    // Single write.
    clr(); base = rsp_cnt;
    do_req(0, 0, 8'h3C, 8'hA5);
    wait_rsp(base + 1);
    chk("wr_frames", frames.size(), 2);
    if (frames.size() == 2) begin
      chk("wr_frame0", frames[0], 11'h03C);
      chk("wr_frame1", frames[1], 11'h1A5);
    end
    if (rsp_cyc.size() == 1 && acc_cyc.size() == 1) begin
      chk("wr_latency", rsp_cyc[0] - acc_cyc[0] + 1, 26);
      chk("wr_rid", rid[0], 0);
      chk("wr_rdata", rdat[0], 0);
    end

    // Read back through requester 1.
    clr(); base = rsp_cnt;
    do_req(1, 1, 8'h3C, 8'h00);
    wait_rsp(base + 1);
    chk("rd_frames", frames.size(), 2);
    if (frames.size() == 2) begin
      chk("rd_frame0", frames[0], 11'h63C);
      chk("rd_frame1", frames[1], 11'h700);
    end
    if (rsp_cyc.size() == 1 && acc_cyc.size() == 1) begin
      chk("rd_latency", rsp_cyc[0] - acc_cyc[0] + 1, 36);
      chk("rd_rid", rid[0], 1);
      chk("rd_rdata", rdat[0], 8'hA5);
    end

    // Back-to-back writes: second grant the cycle after the first response.
    clr(); base = rsp_cnt;
    do_req(0, 0, 8'h20, 8'h55);
    do_req(1, 0, 8'h21, 8'hAA);
    wait_rsp(base + 2);
    chk("b2b_frames", frames.size(), 4);
    if (acc_cyc.size() == 2 && rsp_cyc.size() == 2)
      chk("b2b_next_ready", acc_cyc[1] - rsp_cyc[0], 1);
    if (frames.size() == 4) chk("b2b_frame3", frames[3], 11'h1AA);

    // Reset at bit 5 of the write-data frame.
    clr(); base = rsp_cnt;
    do_req(0, 0, 8'h30, 8'h77);
    repeat (17) @(posedge clk);
    #1 rst_n = 0;
    @(negedge clk);
    chk("abort_ss_n", bus.SS_n, 1);
    chk("abort_mosi", bus.MOSI, 0);
    chk("abort_frames_seen", frames.size(), 1);
    @(posedge clk); #1 rst_n = 1;
    bus.req0_rw = 0; bus.req0_addr = 8'h31; bus.req0_wdata = 8'h01; bus.req0_valid = 1;
    bus.req1_rw = 1; bus.req1_addr = 8'h31; bus.req1_wdata = 8'h00; bus.req1_valid = 1;
    for (int n = 0; n < 50 && gid.size() < 2; n++) @(negedge clk);
    @(posedge clk); #1 bus.req0_valid = 0; bus.req1_valid = 0;
    chk("abort_no_rsp", rsp_cnt, base);
    if (gid.size() == 2) chk("abort_first_grant", gid[1], 0);
    wait_rsp(base + 1);

`ifdef SPI_ADDR_CACHE_EN
    // Repeated write address skips the address frame.
    clr(); base = rsp_cnt;
    do_req(0, 0, 8'h10, 8'h01);
    wait_rsp(base + 1);
    do_req(0, 0, 8'h10, 8'h02);
    wait_rsp(base + 2);
    chk("cache_frames", frames.size(), 3);
    if (frames.size() == 3) chk("cache_frame2", frames[2], 11'h102);
    if (acc_cyc.size() == 2 && rsp_cyc.size() == 2)
      chk("cache_latency", rsp_cyc[1] - acc_cyc[1] + 1, 14);
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
